alarm_snooze_ctrl: RTL
======================

// Module: alarm_snooze_ctrl
// PURPOSE
//  Programming/response side of the alarm-clock alarm interface. Drives the target
//  alarm_hours/alarm_minutes/alarm_seconds into the clock counter and consumes its
//  time fields and alarm pulse. Owns arm/ring/snooze/dismiss sequencing, re-targets
//  the alarm on snooze and drives the buzzer.
// PARAMETERS
//  TW           2  width of each time field; day modulus = 2^(3*TW) ticks
//  SNOOZE_SECS  2  ticks added to current time on snooze, 1..2^(3*TW)-1
//  MAX_SNOOZE   2  snoozes allowed per alarm event, >=1
//  RING_TIMEOUT 8  cycles RINGING lasts without a button before auto-action, >=2
// PORTS
//  clk           in   1   clock
//  reset         in   1   synchronous, active-high reset
//  hours         in   TW  current time from clock counter
//  minutes       in   TW  current time from clock counter
//  seconds       in   TW  current time from clock counter
//  alarm         in   1   match pulse from clock counter
//  arm_en        in   1   level; 0 forces DISARMED
//  set_valid     in   1   1-cycle strobe: load set_h/m/s as base alarm time
//  set_h,set_m,set_s in TW each  new base alarm time
//  snooze        in   1   1-cycle button strobe
//  dismiss       in   1   1-cycle button strobe
//  alarm_hours   out  TW  active target to clock counter (registered)
//  alarm_minutes out  TW  active target (registered)
//  alarm_seconds out  TW  active target (registered)
//  buzzer        out  1   high exactly while state==RINGING (registered)
//  state         out  2   0 DISARMED, 1 ARMED, 2 RINGING, 3 SNOOZING
//  snooze_cnt    out  clog2(MAX_SNOOZE+1)  snoozes used in current event
// BEHAVIOUR
//  Reset: targets=0, base=0, buzzer=0, state=DISARMED, snooze_cnt=0, ring_cnt=0.
//  All updates on clk rising edge; all outputs registered; 1-cycle latency.
//  Priority per cycle: reset > set_valid > !arm_en > dismiss > snooze > timeout > alarm.
//  set_valid (any state): base<=target<=set_*; snooze_cnt<=0; state<=arm_en?ARMED:DISARMED.
//  !arm_en: state<=DISARMED, target<=base, snooze_cnt<=0. arm_en rise while
//   DISARMED: ARMED next cycle, target=base.
//  DISARMED: alarm, snooze, dismiss ignored.
//  ARMED/SNOOZING: alarm=1 -> RINGING, ring_cnt<=0. dismiss -> ARMED, target<=base,
//   snooze_cnt<=0. snooze ignored.
//  RINGING: ring_cnt increments each cycle.
//   dismiss -> ARMED, target<=base, snooze_cnt<=0.
//   snooze with snooze_cnt<MAX_SNOOZE -> SNOOZING, snooze_cnt+1,
//    {alarm_hours,alarm_minutes,alarm_seconds} <= ({hours,minutes,seconds}
//    + SNOOZE_SECS) mod 2^(3*TW), using time inputs sampled on that edge.
//   snooze with snooze_cnt==MAX_SNOOZE: ignored, stays RINGING.
//   ring_cnt==RING_TIMEOUT-1, no button: snooze action if snooze_cnt<MAX_SNOOZE,
//    else dismiss action. buzzer is high exactly RING_TIMEOUT cycles.
//   alarm while RINGING: ignored, ring_cnt not restarted.
//  Wrap: snooze target wraps through 3..3..3 -> 0..0..0; carries ripple across fields.
//  base is never changed by snooze; only set_valid or reset changes base.
// TESTING
//  1 reset; arm_en=1, alarm=1 with no set -> ARMED(target 0,0,0) then RINGING, buzzer=1.
//  2 set 1,2,3; alarm pulse -> buzzer=1 next cycle, state=2; dismiss -> state=1,
//    target 1,2,3, buzzer=0 next cycle.
//  3 RINGING at time 1,2,3, snooze -> target 1,3,1, snooze_cnt=1, state=3;
//    at time 3,3,3, snooze -> target 0,0,1 (wrap).
//  4 snooze_cnt=2, snooze -> ignored, buzzer stays 1; 8 idle cycles -> ARMED, target base, cnt=0.
//  5 snooze_cnt=0, no button -> buzzer high exactly 8 cycles, then SNOOZING, cnt=1.
//  6 snooze+dismiss same cycle -> ARMED, cnt=0; set_valid in RINGING -> ARMED, new
//    target, buzzer=0; arm_en=0 while RINGING -> DISARMED; reset mid-ring -> all zero.

Source files
------------

// File: rtl/alarm_snooze_ctrl.sv
// Alarm programming/response controller: holds the base alarm time, sequences
// arm/ring/snooze/dismiss, re-targets the clock counter on snooze and drives the buzzer.
module alarm_snooze_ctrl #(
    parameter int TW           = 2,
    parameter int SNOOZE_SECS  = 2,
    parameter int MAX_SNOOZE   = 2,
    parameter int RING_TIMEOUT = 8
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [TW-1:0]                   hours,
    input  logic [TW-1:0]                   minutes,
    input  logic [TW-1:0]                   seconds,
    input  logic                            alarm,
    input  logic                            arm_en,
    input  logic                            set_valid,
    input  logic [TW-1:0]                   set_h,
    input  logic [TW-1:0]                   set_m,
    input  logic [TW-1:0]                   set_s,
    input  logic                            snooze,
    input  logic                            dismiss,
    output logic [TW-1:0]                   alarm_hours,
    output logic [TW-1:0]                   alarm_minutes,
    output logic [TW-1:0]                   alarm_seconds,
    output logic                            buzzer,
    output logic [1:0]                      state,
    output logic [$clog2(MAX_SNOOZE+1)-1:0] snooze_cnt
);

    localparam int TTW = 3 * TW;
    localparam int SCW = $clog2(MAX_SNOOZE + 1);
    localparam int RCW = (RING_TIMEOUT > 2) ? $clog2(RING_TIMEOUT) : 1;

    localparam logic [SCW-1:0] MAX_CNT  = SCW'(MAX_SNOOZE);
    localparam logic [RCW-1:0] RING_END = RCW'(RING_TIMEOUT - 1);

    typedef enum logic [1:0] {
        DISARMED = 2'd0,
        ARMED    = 2'd1,
        RINGING  = 2'd2,
        SNOOZING = 2'd3
    } state_t;

    state_t          r_state,  w_state_nx;
    logic [TTW-1:0]  r_target, w_target_nx;
    logic [TTW-1:0]  r_base,   w_base_nx;
    logic [SCW-1:0]  r_cnt,    w_cnt_nx;
    logic [RCW-1:0]  r_ring,   w_ring_nx;
    logic            r_buzzer;
    logic [TTW-1:0]  w_snz_target;
    logic            w_can_snooze;

    // The three time fields form one base-2^TW number, so a plain add carries across fields.
    function automatic logic [TTW-1:0] snooze_target(input logic [TTW-1:0] now);
        return now + TTW'(SNOOZE_SECS);
    endfunction

    assign w_snz_target = snooze_target({hours, minutes, seconds});
    assign w_can_snooze = (r_cnt < MAX_CNT);

    always_comb begin
        w_state_nx  = r_state;
        w_target_nx = r_target;
        w_base_nx   = r_base;
        w_cnt_nx    = r_cnt;
        w_ring_nx   = r_ring;
        if (set_valid) begin
            w_base_nx   = {set_h, set_m, set_s};
            w_target_nx = {set_h, set_m, set_s};
            w_cnt_nx    = '0;
            w_state_nx  = arm_en ? ARMED : DISARMED;
        end else if (!arm_en) begin
            w_state_nx  = DISARMED;
            w_target_nx = r_base;
            w_cnt_nx    = '0;
        end else begin
            case (r_state)
                DISARMED: begin
                    w_state_nx  = ARMED;
                    w_target_nx = r_base;
                end
                ARMED, SNOOZING: begin
                    if (dismiss) begin
                        w_state_nx  = ARMED;
                        w_target_nx = r_base;
                        w_cnt_nx    = '0;
                    end else if (alarm) begin
                        w_state_nx = RINGING;
                        w_ring_nx  = '0;
                    end
                end
                RINGING: begin
                    w_ring_nx = r_ring + RCW'(1);
                    if (dismiss || (r_ring == RING_END && !w_can_snooze &&
                                    !(snooze && w_can_snooze))) begin
                        w_state_nx  = ARMED;
                        w_target_nx = r_base;
                        w_cnt_nx    = '0;
                    end else if (w_can_snooze && (snooze || r_ring == RING_END)) begin
                        w_state_nx  = SNOOZING;
                        w_cnt_nx    = r_cnt + SCW'(1);
                        w_target_nx = w_snz_target;
                    end
                end
                default: w_state_nx = DISARMED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= DISARMED;
            r_target <= '0;
            r_base   <= '0;
            r_cnt    <= '0;
            r_ring   <= '0;
            r_buzzer <= 1'b0;
        end else begin
            r_state  <= w_state_nx;
            r_target <= w_target_nx;
            r_base   <= w_base_nx;
            r_cnt    <= w_cnt_nx;
            r_ring   <= w_ring_nx;
            r_buzzer <= (w_state_nx == RINGING);
        end
    end

    assign {alarm_hours, alarm_minutes, alarm_seconds} = r_target;
    assign buzzer     = r_buzzer;
    assign state      = r_state;
    assign snooze_cnt = r_cnt;

endmodule
